// File: rtl/soc_system_cpu_mult_pkg.sv
// Shared definitions for the CPU multiply cell: op encodings and signedness helpers.
package soc_system_cpu_mult_pkg;

   localparam int MUL_OP_W = 2;

   typedef logic [MUL_OP_W-1:0] mul_op_t;

   localparam mul_op_t MUL_OP_LO  = 2'b00;
   localparam mul_op_t MUL_OP_XUU = 2'b01;
   localparam mul_op_t MUL_OP_XSU = 2'b10;
   localparam mul_op_t MUL_OP_XSS = 2'b11;

   function automatic logic op_src1_signed(input mul_op_t op);
      return (op == MUL_OP_XSU) || (op == MUL_OP_XSS);
   endfunction

   function automatic logic op_src2_signed(input mul_op_t op);
      return (op == MUL_OP_XSS);
   endfunction

endpackage

// File: rtl/soc_system_cpu_mult_pp.sv
// Registered unsigned HALF x HALF partial-product multiplier with enable and async clear.
module soc_system_cpu_mult_pp #(
   parameter int HALF = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_en,
   input  logic [HALF-1:0]   i_a,
   input  logic [HALF-1:0]   i_b,
   output logic [2*HALF-1:0] o_p
);

   logic [2*HALF-1:0] r_p;

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_p <= '0;
      end else if (i_en) begin
         r_p <= i_a * i_b;
      end
   end

   assign o_p = r_p;

endmodule

// File: rtl/soc_system_cpu_mult_cell_ext.sv
// Valid-tagged 2/3-stage multiply cell returning the low or (un)signed high word of src1*src2.
module soc_system_cpu_mult_cell_ext
   import soc_system_cpu_mult_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  mul_op_t           in_op,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_result,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int HALF   = DATA_W / 2;
   localparam int PROD_W = 2 * DATA_W;

   logic              w_en;
   logic [HALF-1:0]   w_a_lo, w_a_hi, w_b_lo, w_b_hi;
   logic [DATA_W-1:0] w_pp_ll, w_pp_lh, w_pp_hl, w_pp_hh;

   assign w_en     = ~stall;
   assign in_ready = ~stall;
   assign {w_a_hi, w_a_lo} = in_src1;
   assign {w_b_hi, w_b_lo} = in_src2;

   soc_system_cpu_mult_pp #(.HALF(HALF)) u_pp_ll (
      .clk(clk), .reset_n(reset_n), .i_en(w_en), .i_a(w_a_lo), .i_b(w_b_lo), .o_p(w_pp_ll)
   );
   soc_system_cpu_mult_pp #(.HALF(HALF)) u_pp_lh (
      .clk(clk), .reset_n(reset_n), .i_en(w_en), .i_a(w_a_lo), .i_b(w_b_hi), .o_p(w_pp_lh)
   );
   soc_system_cpu_mult_pp #(.HALF(HALF)) u_pp_hl (
      .clk(clk), .reset_n(reset_n), .i_en(w_en), .i_a(w_a_hi), .i_b(w_b_lo), .o_p(w_pp_hl)
   );
   soc_system_cpu_mult_pp #(.HALF(HALF)) u_pp_hh (
      .clk(clk), .reset_n(reset_n), .i_en(w_en), .i_a(w_a_hi), .i_b(w_b_hi), .o_p(w_pp_hh)
   );

   // Stage 1 sideband: registered alongside the partial products.
   logic              r_s1_valid;
   mul_op_t           r_s1_op;
   logic              r_s1_neg1, r_s1_neg2;
   logic [DATA_W-1:0] r_s1_src1, r_s1_src2;
   logic [TAG_W-1:0]  r_s1_tag;

   // NOTE: data registers are reset as well, so out_result reads 0 after reset rather than X.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= MUL_OP_LO;
         r_s1_neg1  <= 1'b0;
         r_s1_neg2  <= 1'b0;
         r_s1_src1  <= '0;
         r_s1_src2  <= '0;
         r_s1_tag   <= '0;
      end else begin
         if (flush) begin
            r_s1_valid <= 1'b0;
         end else if (!stall) begin
            r_s1_valid <= in_valid;
         end
         if (!stall) begin
            r_s1_op   <= in_op;
            r_s1_neg1 <= op_src1_signed(in_op) & in_src1[DATA_W-1];
            r_s1_neg2 <= op_src2_signed(in_op) & in_src2[DATA_W-1];
            r_s1_src1 <= in_src1;
            r_s1_src2 <= in_src2;
            r_s1_tag  <= in_tag;
         end
      end
   end

   logic [DATA_W:0]   w_mid;
   logic [PROD_W-1:0] w_prod;
   logic [DATA_W-1:0] w_hi_word;
   logic [DATA_W-1:0] w_s2_result;

   // Signed high words: the unsigned product's upper half minus the other operand per negative signed operand.
   always_comb begin
      w_mid       = {1'b0, w_pp_lh} + {1'b0, w_pp_hl};
      w_prod      = PROD_W'(w_pp_ll)
                  + (PROD_W'(w_mid) << HALF)
                  + (PROD_W'(w_pp_hh) << DATA_W);
      w_hi_word   = w_prod[PROD_W-1:DATA_W]
                  - ({DATA_W{r_s1_neg1}} & r_s1_src2)
                  - ({DATA_W{r_s1_neg2}} & r_s1_src1);
      w_s2_result = (r_s1_op == MUL_OP_LO) ? w_prod[DATA_W-1:0] : w_hi_word;
   end

   logic              w_pre_valid;
   logic [DATA_W-1:0] w_pre_result;
   logic [TAG_W-1:0]  w_pre_tag;

   generate
      if (PIPE_STAGES == 3) begin : g_extra_stage
         logic              r_s2_valid;
         logic [DATA_W-1:0] r_s2_result;
         logic [TAG_W-1:0]  r_s2_tag;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_s2_valid  <= 1'b0;
               r_s2_result <= '0;
               r_s2_tag    <= '0;
            end else begin
               if (flush) begin
                  r_s2_valid <= 1'b0;
               end else if (!stall) begin
                  r_s2_valid <= r_s1_valid;
               end
               if (!stall && !flush && r_s1_valid) begin
                  r_s2_result <= w_s2_result;
                  r_s2_tag    <= r_s1_tag;
               end
            end
         end

         assign w_pre_valid  = r_s2_valid;
         assign w_pre_result = r_s2_result;
         assign w_pre_tag    = r_s2_tag;
      end else begin : g_direct
         assign w_pre_valid  = r_s1_valid;
         assign w_pre_result = w_s2_result;
         assign w_pre_tag    = r_s1_tag;
      end
   endgenerate

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_result;
   logic [TAG_W-1:0]  r_out_tag;

   // Output data only moves on a completed op, so it never drops back to 0 except on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_tag    <= '0;
      end else begin
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (!stall) begin
            r_out_valid <= w_pre_valid;
         end
         if (!stall && !flush && w_pre_valid) begin
            r_out_result <= w_pre_result;
            r_out_tag    <= w_pre_tag;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_soc_system_cpu_mult_cell_ext.sv
// Self-checking bench: directed spec vectors, stall/flush/reset scenarios and a random sweep on three configurations.
module tb_soc_system_cpu_mult_cell_ext;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, in_valid, stall, flush;
   logic [1:0]  in_op;
   logic [63:0] src1, src2;
   logic [4:0]  tag;

   logic        rdy16, rdy32, rdy64, ov16, ov32, ov64;
   logic [15:0] res16;
   logic [31:0] res32;
   logic [63:0] res64;
   logic [4:0]  otag16, otag32, otag64;

   int n_total = 0;
   int n_bad   = 0;

   soc_system_cpu_mult_cell_ext #(.DATA_W(32), .PIPE_STAGES(2), .TAG_W(5)) dut32 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy32), .in_op(in_op),
      .in_src1(src1[31:0]), .in_src2(src2[31:0]), .in_tag(tag), .stall(stall), .flush(flush),
      .out_valid(ov32), .out_result(res32), .out_tag(otag32)
   );
   soc_system_cpu_mult_cell_ext #(.DATA_W(16), .PIPE_STAGES(3), .TAG_W(5)) dut16 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy16), .in_op(in_op),
      .in_src1(src1[15:0]), .in_src2(src2[15:0]), .in_tag(tag), .stall(stall), .flush(flush),
      .out_valid(ov16), .out_result(res16), .out_tag(otag16)
   );
   soc_system_cpu_mult_cell_ext #(.DATA_W(64), .PIPE_STAGES(3), .TAG_W(5)) dut64 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy64), .in_op(in_op),
      .in_src1(src1), .in_src2(src2), .in_tag(tag), .stall(stall), .flush(flush),
      .out_valid(ov64), .out_result(res64), .out_tag(otag64)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
      end
   endtask

   // Reference: exact integer product of the operands interpreted per op, then word select.
   function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
      logic signed [131:0] ea, eb, p;
      logic [63:0]         mask;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      ea = $signed({68'd0, a & mask});
      eb = $signed({68'd0, b & mask});
      if ((op == 2'b10 || op == 2'b11) && a[w-1]) ea = ea - (132'sd1 <<< w);
      if (op == 2'b11 && b[w-1]) eb = eb - (132'sd1 <<< w);
      p = ea * eb;
      if (op == 2'b00) return p[63:0] & mask;
      return 64'(p >>> w) & mask;
   endfunction

   typedef struct {
      logic [4:0]  tag;
      logic [63:0] res;
   } exp_t;

   exp_t q16[$], q32[$], q64[$];

   // Called at posedge+1; one op, then watch all three configurations for its result.
   task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [31:0] want, input string name);
      int          lat32, lat16, lat64;
      logic [31:0] got32;
      logic [4:0]  gtag32, t;
      logic [15:0] got16;
      logic [63:0] got64;
      lat32 = 0; lat16 = 0; lat64 = 0;
      got32 = '0; gtag32 = '0; got16 = '0; got64 = '0;
      t = 5'(op) + 5'd7;
      in_valid = 1'b1; in_op = op; src1 = a; src2 = b; tag = t;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (ov32 && lat32 == 0) begin lat32 = c; got32 = res32; gtag32 = otag32; end
         if (ov16 && lat16 == 0) begin lat16 = c; got16 = res16; end
         if (ov64 && lat64 == 0) begin lat64 = c; got64 = res64; end
      end
      check({name, "_res32"}, 64'(got32), 64'(want));
      check({name, "_tag32"}, 64'(gtag32), 64'(t));
      check({name, "_lat32"}, 64'(lat32), 64'd2);
      check({name, "_lat16"}, 64'(lat16), 64'd3);
      check({name, "_lat64"}, 64'(lat64), 64'd3);
      check({name, "_res16"}, 64'(got16), ref_mul(op, a, b, 16));
      check({name, "_res64"}, got64, ref_mul(op, a, b, 64));
   endtask

   // Called at posedge+1; bit c of each vector is the input for cycle c. Counts out_valid-high samples.
   task automatic run_window(input logic [9:0] v, input logic [9:0] f, input logic [9:0] s,
                             output int c16, output int c32, output int c64);
      c16 = 0; c32 = 0; c64 = 0;
      for (int c = 0; c < 10; c++) begin
         in_valid = v[c]; flush = f[c]; stall = s[c];
         in_op = 2'($urandom_range(3)); src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
         tag = 5'($urandom);
         @(posedge clk); #1;
         if (ov16) c16++;
         if (ov32) c32++;
         if (ov64) c64++;
      end
      in_valid = 1'b0; flush = 1'b0; stall = 1'b0;
   endtask

   task automatic monitor(input logic edge_stall);
      exp_t e;
      if (ov16 && !edge_stall) begin
         if (q16.size() == 0) check("rnd16_unexpected", 64'(ov16), 64'd0);
         else begin
            e = q16.pop_front();
            check("rnd16_res", 64'(res16), e.res);
            check("rnd16_tag", 64'(otag16), 64'(e.tag));
         end
      end
      if (ov32 && !edge_stall) begin
         if (q32.size() == 0) check("rnd32_unexpected", 64'(ov32), 64'd0);
         else begin
            e = q32.pop_front();
            check("rnd32_res", 64'(res32), e.res);
            check("rnd32_tag", 64'(otag32), 64'(e.tag));
         end
      end
      if (ov64 && !edge_stall) begin
         if (q64.size() == 0) check("rnd64_unexpected", 64'(ov64), 64'd0);
         else begin
            e = q64.pop_front();
            check("rnd64_res", res64, e.res);
            check("rnd64_tag", 64'(otag64), 64'(e.tag));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  s_op [1:4];
      logic [31:0] s_a  [1:4];
      logic [31:0] s_b  [1:4];
      int          seq_tag [12];
      logic        seq_stall [12];
      exp_t        cap[$];
      logic        prev_ov;
      logic [31:0] prev_res;
      logic [4:0]  prev_tag;
      int          c16, c32, c64, n_acc, cyc;
      logic        edge_stall;

      reset_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      in_op = 2'b00; src1 = '0; src2 = '0; tag = '0;
      #1;
      check("rst_ov32", 64'(ov32), 64'd0);
      check("rst_res32", 64'(res32), 64'd0);
      check("rst_tag32", 64'(otag32), 64'd0);
      check("rst_ready32", 64'(rdy32), 64'd1);
      check("rst_ov16", 64'(ov16), 64'd0);
      check("rst_res64", res64, 64'd0);
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;

      run_op(2'b00, 64'h0001_0003, 64'h0002_0005, 32'h000B_000F, "small_lo");
      run_op(2'b01, 64'h0001_0003, 64'h0002_0005, 32'h0000_0002, "small_xuu");
      run_op(2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32'h0000_0001, "ones_lo");
      run_op(2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32'hFFFF_FFFE, "ones_xuu");
      run_op(2'b10, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32'hFFFF_FFFF, "ones_xsu");
      run_op(2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32'h0000_0000, "ones_xss");
      run_op(2'b01, 64'h8000_0000, 64'h8000_0000, 32'h4000_0000, "min_xuu");
      run_op(2'b11, 64'h8000_0000, 64'h8000_0000, 32'h4000_0000, "min_xss");
      run_op(2'b10, 64'h8000_0000, 64'h8000_0000, 32'hC000_0000, "min_xsu");

      // Four back-to-back ops with a 3-cycle stall; op 3 is offered throughout the stall.
      for (int i = 1; i <= 4; i++) begin
         s_op[i] = 2'($urandom_range(3)); s_a[i] = $urandom; s_b[i] = $urandom;
      end
      seq_tag   = '{1, 2, 3, 3, 3, 3, 4, 0, 0, 0, 0, 0};
      seq_stall = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      prev_ov = 1'b0; prev_res = '0; prev_tag = '0;
      for (int c = 0; c < 12; c++) begin
         in_valid = (seq_tag[c] != 0);
         if (in_valid) begin
            tag = 5'(seq_tag[c]); in_op = s_op[seq_tag[c]];
            src1 = {32'd0, s_a[seq_tag[c]]}; src2 = {32'd0, s_b[seq_tag[c]]};
         end
         stall = seq_stall[c];
         #1;
         check("stall_ready", 64'(rdy32), 64'(!stall));
         @(posedge clk); #1;
         if (seq_stall[c]) begin
            check("stall_hold_ov", 64'(ov32), 64'(prev_ov));
            check("stall_hold_res", 64'(res32), 64'(prev_res));
            check("stall_hold_tag", 64'(otag32), 64'(prev_tag));
         end else if (ov32) begin
            cap.push_back('{otag32, 64'(res32)});
         end
         prev_ov = ov32; prev_res = res32; prev_tag = otag32;
      end
      in_valid = 1'b0; stall = 1'b0;
      check("stall_count", 64'(cap.size()), 64'd4);
      for (int i = 0; i < 4 && i < cap.size(); i++) begin
         check("stall_order_tag", 64'(cap[i].tag), 64'(i + 1));
         check("stall_order_res", cap[i].res, ref_mul(s_op[i+1], {32'd0, s_a[i+1]}, {32'd0, s_b[i+1]}, 32));
      end

      // Flush with one op in flight and one offered; nothing may emerge anywhere.
      run_window(10'b00_0000_0011, 10'b00_0000_0010, 10'b00_0000_0000, c16, c32, c64);
      check("flush1_ov16", 64'(c16), 64'd0);
      check("flush1_ov32", 64'(c32), 64'd0);
      check("flush1_ov64", 64'(c64), 64'd0);
      // Two in flight plus one offered, flush together with stall, on the 3-stage configurations.
      run_window(10'b00_0000_0111, 10'b00_0000_0100, 10'b00_0000_0100, c16, c32, c64);
      check("flush2_ov16", 64'(c16), 64'd0);
      check("flush2_ov64", 64'(c64), 64'd0);

      // Asynchronous reset between edges while an op sits in stage 1.
      in_valid = 1'b1; in_op = 2'b01; src1 = 64'hFFFF_FFFF_FFFF_FFFF; src2 = 64'h1234_5678_9ABC_DEF1;
      tag = 5'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("arst_ov32", 64'(ov32), 64'd0);
      check("arst_res32", 64'(res32), 64'd0);
      check("arst_tag32", 64'(otag32), 64'd0);
      check("arst_ov64", 64'(ov64), 64'd0);
      check("arst_res16", 64'(res16), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      run_window(10'b0, 10'b0, 10'b0, c16, c32, c64);
      check("arst_after_ov16", 64'(c16), 64'd0);
      check("arst_after_ov32", 64'(c32), 64'd0);
      check("arst_after_ov64", 64'(c64), 64'd0);

      // Random sweep: random valid/stall, all ops, checked in order against the reference model.
      n_acc = 0; cyc = 0;
      @(negedge clk);
      while (n_acc < 10000 && cyc < 30000) begin
         #1;
         in_valid = ($urandom_range(3) != 0);
         stall    = ($urandom_range(7) == 0);
         in_op    = 2'($urandom_range(3));
         src1     = {$urandom, $urandom};
         src2     = {$urandom, $urandom};
         tag      = 5'($urandom);
         @(posedge clk);
         edge_stall = stall;
         if (in_valid && !stall) begin
            n_acc++;
            q16.push_back('{tag, ref_mul(in_op, src1, src2, 16)});
            q32.push_back('{tag, ref_mul(in_op, src1, src2, 32)});
            q64.push_back('{tag, ref_mul(in_op, src1, src2, 64)});
         end
         @(negedge clk);
         monitor(edge_stall);
         cyc++;
      end
      #1;
      in_valid = 1'b0; stall = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         monitor(1'b0);
      end
      check("rand_ops", 64'(n_acc), 64'd10000);
      check("drain16", 64'(q16.size()), 64'd0);
      check("drain32", 64'(q32.size()), 64'd0);
      check("drain64", 64'(q64.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
